// File: rtl/sd_data_rx_block.sv
// rtl/sd_data_rx_block.sv - SD 4-bit DAT block receiver: start bit, payload to FIFO, per-line CRC16, end bit
module sd_data_rx_block #(
    parameter int BLKSIZE_W = 12,
    parameter int TMO_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [BLKSIZE_W-1:0] blk_size_i,
    input  logic [TMO_W-1:0]     timeout_i,
    input  logic [3:0]           sd_dat_i,
    input  logic                 fifo_full_i,
    output logic [3:0]           fifo_dat_o,
    output logic                 fifo_wr_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 crc_ok_o,
    output logic                 err_timeout_o,
    output logic                 err_end_o,
    output logic                 err_ovf_o
);
    localparam int NW = BLKSIZE_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [NW-1:0]   nib_total, nib_cnt;
    logic [TMO_W-1:0] tmo_q, tmo_cnt;
    logic [3:0]      crc_bit_cnt;
    logic [15:0]     crc_q [4];
    logic            crc_ok;

    logic start_ok, start_seen, tmo_hit, last_nib;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign start_ok   = start_i && (blk_size_i != '0);
    assign start_seen = (sd_dat_i == 4'b0000);
    assign tmo_hit    = (tmo_q != '0) && (tmo_cnt == tmo_q - TMO_W'(1));
    assign last_nib   = (nib_cnt == nib_total - NW'(1));

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            S_IDLE: if (start_ok) state_nxt = S_WAIT_START;
            S_WAIT_START: begin
                busy_o = 1'b1;
                if (start_seen)   state_nxt = S_DATA;
                else if (tmo_hit) state_nxt = S_DONE;
            end
            S_DATA: begin
                busy_o = 1'b1;
                if (last_nib) state_nxt = S_CRC;
            end
            S_CRC: begin
                busy_o = 1'b1;
                if (crc_bit_cnt == 4'd15) state_nxt = S_END;
            end
            S_END: begin
                busy_o    = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort_i) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            nib_total     <= '0;
            nib_cnt       <= '0;
            tmo_q         <= '0;
            tmo_cnt       <= '0;
            crc_bit_cnt   <= '0;
            crc_ok        <= 1'b0;
            fifo_dat_o    <= '0;
            fifo_wr_o     <= 1'b0;
            crc_ok_o      <= 1'b0;
            err_timeout_o <= 1'b0;
            err_end_o     <= 1'b0;
            err_ovf_o     <= 1'b0;
            for (int l = 0; l < 4; l++) crc_q[l] <= '0;
        end else begin
            state     <= state_nxt;
            fifo_wr_o <= 1'b0;
            // Abort freezes the datapath; status flags keep whatever they held.
            if (!abort_i) begin
                case (state)
                    S_IDLE: if (start_ok) begin
                        nib_total     <= {blk_size_i, 1'b0};
                        tmo_q         <= timeout_i;
                        tmo_cnt       <= '0;
                        nib_cnt       <= '0;
                        crc_bit_cnt   <= '0;
                        crc_ok        <= 1'b0;
                        crc_ok_o      <= 1'b0;
                        err_timeout_o <= 1'b0;
                        err_end_o     <= 1'b0;
                        err_ovf_o     <= 1'b0;
                        for (int l = 0; l < 4; l++) crc_q[l] <= '0;
                    end
                    S_WAIT_START: if (!start_seen) begin
                        if (tmo_hit)            err_timeout_o <= 1'b1;
                        else if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                    S_DATA: begin
                        nib_cnt    <= nib_cnt + NW'(1);
                        fifo_dat_o <= sd_dat_i;
                        // The card cannot be stalled, so a full FIFO drops the nibble.
                        if (fifo_full_i) err_ovf_o <= 1'b1;
                        else             fifo_wr_o <= 1'b1;
                        for (int l = 0; l < 4; l++) crc_q[l] <= crc_step(crc_q[l], sd_dat_i[l]);
                        if (last_nib) begin
                            crc_ok      <= 1'b1;
                            crc_bit_cnt <= '0;
                        end
                    end
                    S_CRC: begin
                        crc_bit_cnt <= crc_bit_cnt + 4'd1;
                        for (int l = 0; l < 4; l++)
                            if (sd_dat_i[l] != crc_q[l][4'd15 - crc_bit_cnt]) crc_ok <= 1'b0;
                    end
                    S_END: begin
                        if (sd_dat_i != 4'b1111) err_end_o <= 1'b1;
                        crc_ok_o <= crc_ok;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_data_rx_block.sv
// tb/tb_sd_data_rx_block.sv - randomized bench for sd_data_rx_block with polynomial-division CRC model
module tb_sd_data_rx_block;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i, fifo_full_i;
    logic [11:0] blk_size_i;
    logic [15:0] timeout_i;
    logic [3:0]  sd_dat_i;
    logic [3:0]  fifo_dat_o;
    logic        fifo_wr_o, busy_o, done_o, crc_ok_o, err_timeout_o, err_end_o, err_ovf_o;

    sd_data_rx_block dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .blk_size_i(blk_size_i), .timeout_i(timeout_i), .sd_dat_i(sd_dat_i),
        .fifo_full_i(fifo_full_i), .fifo_dat_o(fifo_dat_o), .fifo_wr_o(fifo_wr_o),
        .busy_o(busy_o), .done_o(done_o), .crc_ok_o(crc_ok_o),
        .err_timeout_o(err_timeout_o), .err_end_o(err_end_o), .err_ovf_o(err_ovf_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [3:0] pay [0:15];
    logic [3:0] exp_q [$];
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // CRC as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, by long division.
    function automatic logic [15:0] crc_div(input int line, input int n);
        logic bits [0:127];
        logic [16:0] g;
        logic [15:0] r;
        g = 17'h11021;
        for (int i = 0; i < 128; i++) bits[i] = 1'b0;
        for (int i = 0; i < n; i++) bits[i] = pay[i][line];
        for (int i = 0; i < n; i++)
            if (bits[i])
                for (int j = 0; j <= 16; j++) bits[i+j] = bits[i+j] ^ g[16-j];
        for (int k = 0; k < 16; k++) r[15-k] = bits[n+k];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("done_o", done_o, exp_done);
            chk("busy_o", busy_o, exp_busy);
            if (fifo_wr_o) begin
                if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                else chk("fifo_dat", fifo_dat_o, exp_q.pop_front());
            end
        end
    end

    task automatic do_start(input int blk, input int tmo);
        blk_size_i = 12'(blk);
        timeout_i  = 16'(tmo);
        sd_dat_i   = 4'hF;
        start_i    = 1'b1;
        cyc();
        start_i  = 1'b0;
        exp_busy = 1'b1;
    endtask

    task automatic run_block(input int blk, input int tmo, input int idle, input int flip_line,
                             input int flip_bit, input logic [3:0] endn,
                             input logic [63:0] full_mask, input int abort_after);
        int n;
        logic [15:0] crcs [4];
        logic ovf;
        logic [3:0] v;
        n   = 2 * blk;
        ovf = 1'b0;
        for (int l = 0; l < 4; l++) crcs[l] = crc_div(l, n);
        do_start(blk, tmo);
        for (int k = 0; k < idle; k++) begin
            sd_dat_i = 4'($urandom_range(1, 15));
            cyc();
        end
        sd_dat_i = 4'h0;
        cyc();
        for (int i = 0; i < n; i++) begin
            sd_dat_i = pay[i];
            if (i == abort_after) begin
                abort_i = 1'b1;
                cyc();
                abort_i  = 1'b0;
                exp_busy = 1'b0;
                sd_dat_i = 4'hF;
                repeat (3) cyc();
                chk("abort_no_pending_writes", exp_q.size(), 0);
                chk("abort_err_end", err_end_o, 0);
                chk("abort_err_ovf", err_ovf_o, 0);
                chk("abort_crc_ok", crc_ok_o, 0);
                return;
            end
            fifo_full_i = full_mask[i];
            if (full_mask[i]) ovf = 1'b1;
            else exp_q.push_back(pay[i]);
            cyc();
        end
        fifo_full_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int l = 0; l < 4; l++)
                v[l] = crcs[l][15-i] ^ ((l == flip_line) && (15 - i == flip_bit));
            sd_dat_i = v;
            cyc();
        end
        sd_dat_i = endn;
        cyc();
        exp_busy = 1'b0;
        exp_done = 1'b1;
        sd_dat_i = 4'hF;
        cyc();
        exp_done = 1'b0;
        chk("writes_drained", exp_q.size(), 0);
        chk("crc_ok_o", crc_ok_o, (flip_bit < 0) ? 1 : 0);
        chk("err_end_o", err_end_o, (endn != 4'hF) ? 1 : 0);
        chk("err_ovf_o", err_ovf_o, ovf);
        chk("err_timeout_o", err_timeout_o, 0);
    endtask

    task automatic run_timeout(input int tmo);
        do_start(1, tmo);
        for (int k = 0; k < tmo; k++) begin
            sd_dat_i = (k == 3) ? 4'b0001 : 4'($urandom_range(1, 15));
            cyc();
        end
        exp_busy = 1'b0;
        exp_done = 1'b1;
        sd_dat_i = 4'hF;
        cyc();
        exp_done = 1'b0;
        chk("tmo_err_timeout", err_timeout_o, 1);
        chk("tmo_crc_ok", crc_ok_o, 0);
        chk("tmo_err_end", err_end_o, 0);
        chk("tmo_err_ovf", err_ovf_o, 0);
        chk("tmo_no_writes", exp_q.size(), 0);
    endtask

    task automatic load_seq();
        for (int i = 0; i < 16; i++) pay[i] = 4'(i + 1);
    endtask

    initial begin
        int blk, idle, tmo, fl, fb;
        logic [3:0] endn;
        logic [63:0] fm;
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; fifo_full_i = 1'b0;
        blk_size_i = '0; timeout_i = '0; sd_dat_i = 4'hF;
        repeat (3) cyc();
        chk("rst_fifo_wr", fifo_wr_o, 0);
        chk("rst_fifo_dat", fifo_dat_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_crc_ok", crc_ok_o, 0);
        chk("rst_flags", {err_timeout_o, err_end_o, err_ovf_o}, 0);
        rst = 1'b0;
        cyc();

        pay[0] = 4'h1; pay[1] = 4'h0;
        chk("model_crc_one", crc_div(0, 1), 16'h1021);
        chk("model_crc_zero", crc_div(1, 1), 16'h0000);
        chk("model_crc_x17", crc_div(0, 2), 16'h2042);

        // zero block size and start-with-abort are both refused (busy checked every cycle)
        blk_size_i = 12'd0; start_i = 1'b1; cyc(); start_i = 1'b0; cyc();
        blk_size_i = 12'd4; start_i = 1'b1; abort_i = 1'b1; cyc();
        start_i = 1'b0; abort_i = 1'b0; cyc();

        load_seq(); run_block(4, 100, 3, -1, -1, 4'hF, 64'h0, -1);
        load_seq(); run_block(4, 100, 3, 2, 5, 4'hF, 64'h0, -1);
        run_timeout(10);
        load_seq(); run_block(4, 100, 3, -1, -1, 4'hF, 64'hC, -1);
        load_seq(); run_block(4, 100, 3, -1, -1, 4'b0111, 64'h0, -1);
        load_seq(); run_block(4, 100, 3, -1, -1, 4'hF, 64'h0, 3);
        load_seq(); run_block(4, 100, 3, -1, -1, 4'hF, 64'h0, -1);
        load_seq(); run_block(8, 0, 0, -1, -1, 4'hF, 64'h0, -1);

        for (int r = 0; r < 30; r++) begin
            blk  = $urandom_range(1, 8);
            idle = $urandom_range(0, 5);
            for (int i = 0; i < 16; i++) pay[i] = 4'($urandom);
            case ($urandom_range(0, 2))
                0: tmo = 0;
                1: tmo = idle + 1;
                default: tmo = idle + 1 + $urandom_range(1, 30);
            endcase
            fl = $urandom_range(0, 3);
            fb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
            endn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            fm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) run_timeout($urandom_range(4, 20));
            else run_block(blk, tmo, idle, fl, fb, endn, fm, -1);
        end
        repeat (3) cyc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
